// File: rtl/fsm_seq_pkg.sv
// Shared state codes, LED patterns and small decode helpers for the four-phase sequencer.
package fsm_seq_pkg;

    localparam int FSM_STATE_W = 3;

    localparam logic [FSM_STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [FSM_STATE_W-1:0] ST_COUNT = 3'd1;
    localparam logic [FSM_STATE_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [FSM_STATE_W-1:0] ST_DONE  = 3'd3;
    localparam logic [FSM_STATE_W-1:0] ST_FAULT = 3'd4;

    localparam logic [7:0] LED_IDLE  = 8'h00;
    localparam logic [7:0] LED_COUNT = 8'h0A;
    localparam logic [7:0] LED_WAIT  = 8'h05;
    localparam logic [7:0] LED_DONE  = 8'h0F;
    localparam logic [7:0] LED_FAULT = 8'h11;

    // Unused codes map to the idle pattern so the LED bank never shows garbage.
    function automatic logic [7:0] led_pattern(input logic [FSM_STATE_W-1:0] st);
        logic [7:0] pat;
        case (st)
            ST_IDLE:  pat = LED_IDLE;
            ST_COUNT: pat = LED_COUNT;
            ST_WAIT:  pat = LED_WAIT;
            ST_DONE:  pat = LED_DONE;
            ST_FAULT: pat = LED_FAULT;
            default:  pat = LED_IDLE;
        endcase
        return pat;
    endfunction

    function automatic logic is_busy(input logic [FSM_STATE_W-1:0] st);
        logic b;
        case (st)
            ST_COUNT: b = 1'b1;
            ST_WAIT:  b = 1'b1;
            ST_DONE:  b = 1'b1;
            default:  b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV running cycles; clear has priority over run.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int DIV_W = (TICK_DIV < 32'd2) ? 1 : $clog2(TICK_DIV + 32'd1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 32'd1);

    logic [DIV_W-1:0] div_r;

    if (TICK_DIV < 32'd1) begin : g_bad_div
        $error("tick_prescaler: TICK_DIV must be at least 1");
    end

    assign tick = run & (div_r == DIV_LAST);

    // Divider counter: holds when neither run nor clear is asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= '0;
        end else if (clear) begin
            div_r <= '0;
        end else if (run) begin
            if (div_r == DIV_LAST) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end else begin
            div_r <= div_r;
        end
    end

endmodule

// File: rtl/fsm_sequencer.sv
// Four-phase sequencer IDLE -> COUNT -> WAIT -> DONE with WAIT timeout to FAULT and global abort.
module fsm_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 10_000_000,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned COUNT_TARGET = 3,
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   ack,
    input  logic                   abort,
    output logic [7:0]             led_out,
    output logic [FSM_STATE_W-1:0] state_out,
    output logic [CNT_W-1:0]       count_out,
    output logic                   busy,
    output logic                   done_pulse
);

    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_TARGET - 32'd1);
    localparam logic [CNT_W-1:0] WT_LAST  = CNT_W'(WAIT_TIMEOUT - 32'd1);

    if (COUNT_TARGET < 32'd1 || COUNT_TARGET > CNT_MAX) begin : g_bad_target
        $error("fsm_sequencer: COUNT_TARGET out of range 1..2**CNT_W-1");
    end
    if (WAIT_TIMEOUT < 32'd1 || WAIT_TIMEOUT > CNT_MAX) begin : g_bad_timeout
        $error("fsm_sequencer: WAIT_TIMEOUT out of range 1..2**CNT_W-1");
    end

    logic                   start_q_r;
    logic                   ack_q_r;
    logic                   start_rise_s;
    logic                   ack_rise_s;
    logic [FSM_STATE_W-1:0] state_r;
    logic [FSM_STATE_W-1:0] state_nx_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nx_s;
    logic [CNT_W-1:0]       wt_r;
    logic [CNT_W-1:0]       wt_nx_s;
    logic [7:0]             led_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   in_phase_s;
    logic                   run_s;
    logic                   clear_s;
    logic                   tick_s;

    assign start_rise_s = start & ~start_q_r;
    assign ack_rise_s   = ack & ~ack_q_r;

    // Abort also wipes the prescaler so a restarted run gets a full first tick period.
    assign in_phase_s = (state_r == ST_COUNT) || (state_r == ST_WAIT);
    assign run_s      = enable & in_phase_s & ~abort;
    assign clear_s    = enable & ~run_s;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run_s),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Input history for edge detection; keeps sampling while enable is low so edges then are lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q_r <= 1'b0;
            ack_q_r   <= 1'b0;
        end else begin
            start_q_r <= start;
            ack_q_r   <= ack;
        end
    end

    // Next-state and phase-counter logic; abort outranks every other transition.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        wt_nx_s    = wt_r;
        if (abort) begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = '0;
            wt_nx_s    = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_rise_s) begin
                        state_nx_s = ST_COUNT;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_COUNT: begin
                    if (tick_s) begin
                        if (cnt_r == CNT_LAST) begin
                            state_nx_s = ST_WAIT;
                            cnt_nx_s   = '0;
                        end else begin
                            cnt_nx_s   = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_nx_s = ST_COUNT;
                    end
                end
                ST_WAIT: begin
                    // A handshake landing on the final timeout tick still completes the run.
                    if (ack_rise_s) begin
                        state_nx_s = ST_DONE;
                        wt_nx_s    = '0;
                    end else if (tick_s) begin
                        if (wt_r == WT_LAST) begin
                            state_nx_s = ST_FAULT;
                            wt_nx_s    = '0;
                        end else begin
                            wt_nx_s    = wt_r + CNT_W'(1);
                        end
                    end else begin
                        state_nx_s = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    if (ack_rise_s) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end
                ST_FAULT: begin
                    state_nx_s = ST_FAULT;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = '0;
                    wt_nx_s    = '0;
                end
            endcase
        end
    end

    // State, counters and outputs; outputs derive from the next state so they stay coherent with state_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            wt_r    <= '0;
            led_r   <= LED_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (enable) begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            wt_r    <= wt_nx_s;
            led_r   <= led_pattern(state_nx_s);
            busy_r  <= is_busy(state_nx_s);
            done_r  <= (state_nx_s == ST_DONE) && (state_r != ST_DONE);
        end else begin
            done_r  <= 1'b0;
        end
    end

    assign state_out  = state_r;
    assign count_out  = cnt_r;
    assign led_out    = led_r;
    assign busy       = busy_r;
    assign done_pulse = done_r;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Directed bench: dut4 uses TICK_DIV=4, dut1 uses TICK_DIV=1; both COUNT_TARGET=3, WAIT_TIMEOUT=4.
module tb_fsm_sequencer;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       start;
    logic       ack;
    logic       abort;

    logic [7:0] d4_led;
    logic [2:0] d4_state;
    logic [7:0] d4_count;
    logic       d4_busy;
    logic       d4_done;
    logic [7:0] d1_led;
    logic [2:0] d1_state;
    logic [7:0] d1_count;
    logic       d1_busy;
    logic       d1_done;

    int checks;
    int failures;

    fsm_sequencer #(.TICK_DIV(4), .CNT_W(8), .COUNT_TARGET(3), .WAIT_TIMEOUT(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .ack(ack), .abort(abort),
        .led_out(d4_led), .state_out(d4_state), .count_out(d4_count),
        .busy(d4_busy), .done_pulse(d4_done)
    );

    fsm_sequencer #(.TICK_DIV(1), .CNT_W(8), .COUNT_TARGET(3), .WAIT_TIMEOUT(4)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .ack(ack), .abort(abort),
        .led_out(d1_led), .state_out(d1_state), .count_out(d1_count),
        .busy(d1_busy), .done_pulse(d1_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; start = 1'b0; ack = 1'b0; abort = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (d4_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", d4_state); end
        checks++; if (d4_led !== 8'h00) begin failures++; $display("FAIL reset_led got=%h exp=00", d4_led); end
        checks++; if (d4_count !== 8'd0 || d4_busy !== 1'b0 || d4_done !== 1'b0) begin
            failures++; $display("FAIL reset_outs count=%0d busy=%b done=%b exp 0/0/0", d4_count, d4_busy, d4_done); end
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(12);
        checks++; if (d4_state !== 3'd2) begin failures++; $display("FAIL pre_reset_wait got=%0d exp=2", d4_state); end
        cyc(2);
        reset = 1'b1; cyc(1);
        checks++; if (d4_state !== 3'd0 || d4_led !== 8'h00) begin
            failures++; $display("FAIL midrun_reset state=%0d led=%h exp 0/00", d4_state, d4_led); end
        cyc(1); reset = 1'b0;
        checks++; if (d4_busy !== 1'b0 || d4_count !== 8'd0) begin
            failures++; $display("FAIL midrun_reset_outs busy=%b count=%0d exp 0/0", d4_busy, d4_count); end
    endtask

    task automatic test_count();
        do_reset();
        start = 1'b1;
        checks++; if (d4_state !== 3'd0) begin failures++; $display("FAIL start_latency got=%0d exp=0", d4_state); end
        cyc(1); start = 1'b0;
        checks++; if (d4_led !== 8'h0A || d4_busy !== 1'b1) begin
            failures++; $display("FAIL count_entry led=%h busy=%b exp 0A/1", d4_led, d4_busy); end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (d4_state !== 3'd1 || d4_count !== 8'(k / 4)) begin
                failures++; $display("FAIL count_seq k=%0d state=%0d count=%0d exp 1/%0d", k, d4_state, d4_count, k / 4);
            end
            cyc(1);
        end
        checks++; if (d4_state !== 3'd2 || d4_led !== 8'h05 || d4_count !== 8'd0) begin
            failures++; $display("FAIL wait_entry state=%0d led=%h count=%0d exp 2/05/0", d4_state, d4_led, d4_count); end
    endtask

    task automatic test_ack();
        ack = 1'b1; cyc(1);
        checks++; if (d4_state !== 3'd3 || d4_led !== 8'h0F || d4_done !== 1'b1) begin
            failures++; $display("FAIL done_entry state=%0d led=%h done=%b exp 3/0F/1", d4_state, d4_led, d4_done); end
        cyc(1);
        checks++; if (d4_done !== 1'b0 || d4_state !== 3'd3) begin
            failures++; $display("FAIL done_pulse_width done=%b state=%0d exp 0/3", d4_done, d4_state); end
        cyc(3); ack = 1'b0; cyc(1);
        checks++; if (d4_state !== 3'd3) begin failures++; $display("FAIL ack_held got=%0d exp=3", d4_state); end
        ack = 1'b1; cyc(1); ack = 1'b0;
        checks++; if (d4_state !== 3'd0 || d4_led !== 8'h00 || d4_busy !== 1'b0) begin
            failures++; $display("FAIL done_to_idle state=%0d led=%h busy=%b exp 0/00/0", d4_state, d4_led, d4_busy); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; cyc(1); start = 1'b0;
        checks++; if (d4_state !== 3'd1) begin failures++; $display("FAIL back_to_back got=%0d exp=1", d4_state); end
    endtask

    task automatic test_fault();
        do_reset();
        start = 1'b1; cyc(1); start = 1'b0;
        checks++; if (d1_state !== 3'd1) begin failures++; $display("FAIL d1_count_entry got=%0d exp=1", d1_state); end
        cyc(2);
        checks++; if (d1_state !== 3'd1 || d1_count !== 8'd2) begin
            failures++; $display("FAIL d1_count2 state=%0d count=%0d exp 1/2", d1_state, d1_count); end
        cyc(1);
        checks++; if (d1_state !== 3'd2 || d1_led !== 8'h05) begin
            failures++; $display("FAIL d1_wait_entry state=%0d led=%h exp 2/05", d1_state, d1_led); end
        cyc(3);
        checks++; if (d1_state !== 3'd2) begin failures++; $display("FAIL d1_wait_hold got=%0d exp=2", d1_state); end
        cyc(1);
        checks++; if (d1_state !== 3'd4 || d1_led !== 8'h11 || d1_busy !== 1'b0 || d1_done !== 1'b0) begin
            failures++; $display("FAIL d1_fault state=%0d led=%h busy=%b done=%b exp 4/11/0/0", d1_state, d1_led, d1_busy, d1_done); end
        start = 1'b1; cyc(1); start = 1'b0; cyc(1); start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        checks++; if (d1_state !== 3'd4) begin failures++; $display("FAIL fault_ignores_start got=%0d exp=4", d1_state); end
        abort = 1'b1; cyc(1); abort = 1'b0;
        checks++; if (d1_state !== 3'd0 || d1_led !== 8'h00) begin
            failures++; $display("FAIL fault_abort state=%0d led=%h exp 0/00", d1_state, d1_led); end
    endtask

    task automatic test_timeout_race();
        do_reset();
        start = 1'b1; cyc(1); start = 1'b0; cyc(12); cyc(15);
        checks++; if (d4_state !== 3'd2) begin failures++; $display("FAIL d4_wait_before_timeout got=%0d exp=2", d4_state); end
        cyc(1);
        checks++; if (d4_state !== 3'd4 || d4_led !== 8'h11) begin
            failures++; $display("FAIL d4_timeout state=%0d led=%h exp 4/11", d4_state, d4_led); end
        do_reset();
        start = 1'b1; cyc(1); start = 1'b0; cyc(12); cyc(15);
        ack = 1'b1; cyc(1); ack = 1'b0;
        checks++; if (d4_state !== 3'd3 || d4_done !== 1'b1) begin
            failures++; $display("FAIL ack_beats_timeout state=%0d done=%b exp 3/1", d4_state, d4_done); end
    endtask

    task automatic test_abort();
        do_reset();
        start = 1'b1; cyc(1); start = 1'b0; cyc(4);
        checks++; if (d4_count !== 8'd1) begin failures++; $display("FAIL pre_abort_count got=%0d exp=1", d4_count); end
        abort = 1'b1; cyc(1); abort = 1'b0;
        checks++; if (d4_state !== 3'd0 || d4_count !== 8'd0 || d4_busy !== 1'b0) begin
            failures++; $display("FAIL abort_count state=%0d count=%0d busy=%b exp 0/0/0", d4_state, d4_count, d4_busy); end
        start = 1'b1; cyc(1); start = 1'b0; cyc(3);
        checks++; if (d4_count !== 8'd0) begin failures++; $display("FAIL restart_prescale_early got=%0d exp=0", d4_count); end
        cyc(1);
        checks++; if (d4_count !== 8'd1) begin failures++; $display("FAIL restart_prescale_tick got=%0d exp=1", d4_count); end
    endtask

    task automatic test_enable();
        do_reset();
        start = 1'b1; cyc(1); start = 1'b0; cyc(5);
        enable = 1'b0; cyc(3); start = 1'b1; cyc(3); start = 1'b0; cyc(4);
        checks++; if (d4_state !== 3'd1 || d4_count !== 8'd1 || d4_led !== 8'h0A || d4_done !== 1'b0) begin
            failures++; $display("FAIL enable_freeze state=%0d count=%0d led=%h done=%b exp 1/1/0A/0", d4_state, d4_count, d4_led, d4_done); end
        enable = 1'b1; cyc(2);
        checks++; if (d4_count !== 8'd1) begin failures++; $display("FAIL resume_before_tick got=%0d exp=1", d4_count); end
        cyc(1);
        checks++; if (d4_count !== 8'd2) begin failures++; $display("FAIL resume_tick got=%0d exp=2", d4_count); end
        cyc(3);
        checks++; if (d4_state !== 3'd1) begin failures++; $display("FAIL resume_still_count got=%0d exp=1", d4_state); end
        cyc(1);
        checks++; if (d4_state !== 3'd2) begin failures++; $display("FAIL resume_wait got=%0d exp=2", d4_state); end
        do_reset();
        enable = 1'b0; start = 1'b1; cyc(2); enable = 1'b1; cyc(2); start = 1'b0;
        checks++; if (d4_state !== 3'd0 || d4_busy !== 1'b0) begin
            failures++; $display("FAIL lost_start_edge state=%0d busy=%b exp 0/0", d4_state, d4_busy); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; enable = 1'b1; start = 1'b0; ack = 1'b0; abort = 1'b0;
        test_reset();
        test_count();
        test_ack();
        test_back_to_back();
        test_fault();
        test_timeout_race();
        test_abort();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
